stepmul_udiv_32ns_16ns_16_seq: RTL and testbench

Sequential unsigned divider that undoes the STEPMUL 16×16→32 product path: it takes a 32-bit unsigned dividend and a 16-bit unsigned divisor and returns a 16-bit quotient and a 16-bit remainder. It uses a restoring algorithm at one quotient bit per cycle, behind the standard block-level start/done/idle/ready handshake. It sits beside the multiplier in the STEPMUL datapath, for reduction and normalisation steps.

---
 rtl/stepmul_udiv_32ns_16ns_16_seq_if.sv | 23 ++
 rtl/stepmul_udiv_32ns_16ns_16_seq.sv | 145 ++++++++++++++
 tb/tb_stepmul_udiv_32ns_16ns_16_seq.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/stepmul_udiv_32ns_16ns_16_seq_if.sv
// Block-level start/done/idle/ready handshake and operand/result bus for the STEPMUL divider.
// The master side issues operands, and the slave side (the divider) returns results.
interface stepmul_udiv_32ns_16ns_16_seq_if;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_done;
  logic        ap_idle;
  logic [31:0] din0;
  logic [15:0] din1;
  logic [15:0] quot;
  logic [15:0] rem;
  logic        ovf;

  modport master (
    output ap_start, din0, din1,
    input  ap_ready, ap_done, ap_idle, quot, rem, ovf
  );

  modport slave (
    input  ap_start, din0, din1,
    output ap_ready, ap_done, ap_idle, quot, rem, ovf
  );
endinterface

// File: rtl/stepmul_udiv_32ns_16ns_16_seq.sv
// Restoring 32/16 unsigned divider: one quotient bit per cycle, 17-cycle latency.
// Optional feature: define STEPMUL_DIV_OVF_CHK_EN for the fast overflow/divide-by-zero path.
module stepmul_udiv_32ns_16ns_16_seq (
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  stepmul_udiv_32ns_16ns_16_seq_if.slave bus
);

  localparam int DIN0_WIDTH = 32;
  localparam int DIN1_WIDTH = 16;
  localparam int DOUT_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DIN1_WIDTH-1:0] r_q, r_d;
  logic [DIN1_WIDTH-1:0] q_q, q_d;
  logic [DIN1_WIDTH-1:0] d_q, d_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DOUT_WIDTH-1:0] quot_q, quot_d;
  logic [DOUT_WIDTH-1:0] rem_q, rem_d;
`ifdef STEPMUL_DIV_OVF_CHK_EN
  logic                  ovf_q, ovf_d;
`endif

  logic [DIN1_WIDTH:0]   t;
  logic                  t_ge_d;
  logic [DIN1_WIDTH-1:0] r_step;
  logic [DIN1_WIDTH-1:0] q_step;
  logic                  ready;
  logic                  idle;
  logic                  done;

  // One restoring step: shift the next dividend bit into the partial remainder.
  always_comb begin
    t      = {r_q, q_q[DIN1_WIDTH-1]};
    t_ge_d = (t >= {1'b0, d_q});
    r_step = t_ge_d ? (t[DIN1_WIDTH-1:0] - d_q) : t[DIN1_WIDTH-1:0];
    q_step = {q_q[DIN1_WIDTH-2:0], t_ge_d};
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef STEPMUL_DIV_OVF_CHK_EN
    ovf_d   = ovf_q;
`endif
    ready   = 1'b0;
    idle    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        idle = 1'b1;
        if (bus.ap_start) begin
          ready   = 1'b1;
          r_d     = bus.din0[DIN0_WIDTH-1:DIN1_WIDTH];
          q_d     = bus.din0[DIN1_WIDTH-1:0];
          d_d     = bus.din1;
          cnt_d   = 4'd0;
          state_d = S_CALC;
`ifdef STEPMUL_DIV_OVF_CHK_EN
          // Quotient cannot fit in 16 bits (or divisor is zero): skip the iteration.
          if (bus.din1 == '0 || bus.din0[DIN0_WIDTH-1:DIN1_WIDTH] >= bus.din1) begin
            state_d = S_DONE;
            quot_d  = '1;
            rem_d   = '1;
            ovf_d   = 1'b1;
          end
`endif
        end
      end
      S_CALC: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = S_DONE;
          quot_d  = q_step;
          rem_d   = r_step;
`ifdef STEPMUL_DIV_OVF_CHK_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples its _d value
  // from before the edge, independent of statement order.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef STEPMUL_DIV_OVF_CHK_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef STEPMUL_DIV_OVF_CHK_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // NOTE: the working registers are deliberately left without reset; they are
  // always loaded on acceptance before being read, so a reset would add nothing.
  always_ff @(posedge ap_clk) begin
    r_q   <= r_d;
    q_q   <= q_d;
    d_q   <= d_d;
    cnt_q <= cnt_d;
  end

  assign bus.ap_ready = ready;
  assign bus.ap_idle  = idle;
  assign bus.ap_done  = done;
  assign bus.quot     = quot_q;
  assign bus.rem      = rem_q;
`ifdef STEPMUL_DIV_OVF_CHK_EN
  assign bus.ovf      = ovf_q;
`else
  assign bus.ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_stepmul_udiv_32ns_16ns_16_seq.sv
// Scoreboard bench for the 32/16 divider: the driver pushes expected results from
// plain / and % arithmetic; an independent monitor pops and compares on ap_done.
module tb_stepmul_udiv_32ns_16ns_16_seq;

  typedef struct {
    logic [15:0] quot;
    logic [15:0] rem;
    logic        ovf;
    int          ready_cyc;
    int          lat;
  } exp_t;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;
  exp_t sb[$];

  stepmul_udiv_32ns_16ns_16_seq_if bus ();

  stepmul_udiv_32ns_16ns_16_seq dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus.slave)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: exact division in range, saturated flags when the check path is built.
  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b, input int rc);
    exp_t e;
    logic [31:0] q32;
    logic [31:0] r32;
    e.ready_cyc = rc;
`ifdef STEPMUL_DIV_OVF_CHK_EN
    if (b == 16'd0 || a[31:16] >= b) begin
      e.quot = 16'hFFFF;
      e.rem  = 16'hFFFF;
      e.ovf  = 1'b1;
      e.lat  = 1;
      return e;
    end
`endif
    q32    = a / {16'd0, b};
    r32    = a % {16'd0, b};
    e.quot = q32[15:0];
    e.rem  = r32[15:0];
    e.ovf  = 1'b0;
    e.lat  = 17;
    return e;
  endfunction

  // Monitor: independent of the driver, reacts only to ap_done.
  always @(negedge ap_clk) begin
    if (bus.ap_done) begin
      exp_t e;
      done_seen++;
      check("ready_done_excl", {31'd0, bus.ap_ready}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("quot", {16'd0, bus.quot}, {16'd0, e.quot});
        check("rem", {16'd0, bus.rem}, {16'd0, e.rem});
        check("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
        check("latency", cyc - e.ready_cyc, e.lat);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge ap_clk);
    while (!bus.ap_idle && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    check("idle_wait", {31'd0, bus.ap_idle}, 32'd1);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [15:0] b, input bit push);
    wait_idle();
    bus.ap_start = 1'b1;
    bus.din0     = a;
    bus.din1     = b;
    #1;
    check("ready", {31'd0, bus.ap_ready}, 32'd1);
    if (push) sb.push_back(model(a, b, cyc));
    @(posedge ap_clk);
    @(negedge ap_clk);
    bus.ap_start = 1'b0;
    bus.din0     = $urandom;
    bus.din1     = 16'($urandom);
  endtask

  initial begin
    int r1;
    int n;
    int d0;
    bus.ap_start = 1'b0;
    bus.din0     = '0;
    bus.din1     = '0;

    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_idle", {31'd0, bus.ap_idle}, 32'd1);
    check("rst_quot", {16'd0, bus.quot}, 32'd0);
    check("rst_rem", {16'd0, bus.rem}, 32'd0);
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    check("rst_ready", {31'd0, bus.ap_ready}, 32'd0);
    ap_rst = 1'b0;
    d0 = done_seen;
    repeat (50) @(negedge ap_clk);
    check("no_done_idle", done_seen - d0, 0);

    // Directed cases, including full-scale quotient and zero quotient.
    do_op(32'd100000, 16'd7, 1'b1);
    do_op(32'hFFFE0001, 16'hFFFF, 1'b1);
    do_op(32'd5, 16'd9, 1'b1);

    // Start held high across two operations; the second accept comes 18 cycles later.
    wait_idle();
    bus.ap_start = 1'b1;
    bus.din0     = 32'd1000;
    bus.din1     = 16'd10;
    #1;
    check("held_ready1", {31'd0, bus.ap_ready}, 32'd1);
    sb.push_back(model(32'd1000, 16'd10, cyc));
    r1 = cyc;
    @(negedge ap_clk);
    bus.din0 = 32'd65535;
    bus.din1 = 16'd256;
    n = 0;
    while (!bus.ap_ready && n < 40) begin
      @(negedge ap_clk);
      n++;
    end
    #1;
    check("held_ready2", {31'd0, bus.ap_ready}, 32'd1);
    check("held_spacing", cyc - r1, 18);
    sb.push_back(model(32'd65535, 16'd256, cyc));
    @(negedge ap_clk);
    bus.ap_start = 1'b0;

    // Reset in the middle of CALC aborts the operation silently.
    do_op(32'd123456, 16'd77, 1'b0);
    repeat (7) @(negedge ap_clk);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    check("abort_idle", {31'd0, bus.ap_idle}, 32'd1);
    check("abort_done", {31'd0, bus.ap_done}, 32'd0);
    check("abort_quot", {16'd0, bus.quot}, 32'd0);
    check("abort_rem", {16'd0, bus.rem}, 32'd0);
    check("abort_ovf", {31'd0, bus.ovf}, 32'd0);
    ap_rst = 1'b0;
    d0 = done_seen;
    repeat (25) @(negedge ap_clk);
    check("abort_no_done", done_seen - d0, 0);
    do_op(32'd81, 16'd9, 1'b1);

`ifdef STEPMUL_DIV_OVF_CHK_EN
    do_op(32'd12345, 16'd0, 1'b1);
    do_op(32'h00010000, 16'd1, 1'b1);
    do_op(32'd100, 16'd3, 1'b1);
`endif

    // Random in-range operands.
    for (int i = 0; i < 24; i++) begin
      logic [15:0] b;
      logic [15:0] hi;
      b  = 16'($urandom_range(1, 65535));
      hi = 16'($urandom % b);
      do_op({hi, 16'($urandom)}, b, 1'b1);
    end

`ifdef STEPMUL_DIV_OVF_CHK_EN
    // Random out-of-range operands take the overflow path.
    for (int i = 0; i < 6; i++) begin
      logic [15:0] b;
      b = 16'($urandom_range(0, 4000));
      do_op({16'($urandom_range(4000, 65535)), 16'($urandom)}, b, 1'b1);
    end
`endif

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    check("sb_drained", sb.size(), 0);
    repeat (3) @(negedge ap_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
